// File: rtl/cmd_packet_tx_if.sv
// Host command channel and outbound command stream of the command-processor link.
interface cmd_packet_tx_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic                  host_valid;
    logic                  host_ready;
    logic [3:0]            host_opcode;
    logic [2:0]            host_argc;
    logic [4*DATA_W-1:0]   host_args;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_W-1:0]     cmd_data;
    logic                  cmd_last;

    // Transmitter side: consumes host commands, produces the stream.
    modport master (
        input  host_valid, host_opcode, host_argc, host_args, cmd_ready,
        output host_ready, cmd_valid, cmd_data, cmd_last
    );

    // Host / command-processor side.
    modport slave (
        output host_valid, host_opcode, host_argc, host_args, cmd_ready,
        input  host_ready, cmd_valid, cmd_data, cmd_last
    );
endinterface

// File: rtl/cmd_packet_tx.sv
// Transmit end of the command-processor input link: queues host commands,
// serializes each as header + argument words, and limits in-flight packets
// with a credit counter returned by engine completion pulses.
module cmd_packet_tx #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_,
    cmd_packet_tx_if.master  bus,
    input  logic             engine_done,
    output logic [3:0]       outstanding,
    output logic             busy,
    output logic             err
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_ARG} state_t;

    // Host command queue
    logic [3:0]          q_op_q   [DEPTH];
    logic [3:0]          q_op_d   [DEPTH];
    logic [2:0]          q_argc_q [DEPTH];
    logic [2:0]          q_argc_d [DEPTH];
    logic [4*DATA_W-1:0] q_args_q [DEPTH];
    logic [4*DATA_W-1:0] q_args_d [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                empty, full;

    // Packet being serialized
    state_t              state_q, state_d;
    logic [3:0]          w_op_q, w_op_d;
    logic [2:0]          w_argc_q, w_argc_d;
    logic [4*DATA_W-1:0] w_args_q, w_args_d;
    logic [1:0]          idx_q, idx_d;

    // Registered stream outputs and bookkeeping
    logic                cmd_valid_q, cmd_valid_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic                cmd_last_q, cmd_last_d;
    logic [7:0]          seq_q, seq_d;
    logic [3:0]          outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic                hdr_xfer;
    logic                credit_ret;
    logic [1:0]          next_idx;
    logic [DATA_W-1:0]   next_arg;
    logic [DATA_W-1:0]   hdr_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign bus.host_ready = !full;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.cmd_last   = cmd_last_q;
    assign outstanding    = outstanding_q;
    assign err            = err_q;
    assign busy           = (state_q != ST_IDLE) || !empty || (outstanding_q != 4'd0);

    // Next-state logic for queue, packet FSM, stream registers and credits.
    always_comb begin
        q_op_d        = q_op_q;
        q_argc_d      = q_argc_q;
        q_args_d      = q_args_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        state_d       = state_q;
        w_op_d        = w_op_q;
        w_argc_d      = w_argc_q;
        w_args_d      = w_args_q;
        idx_d         = idx_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_data_d    = cmd_data_q;
        cmd_last_d    = cmd_last_q;
        seq_d         = seq_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        hdr_xfer      = 1'b0;
        credit_ret    = 1'b0;
        next_idx      = idx_q + 2'd1;
        next_arg      = '0;

        for (int unsigned k = 0; k < 4; k++) begin
            if (next_idx == k[1:0]) begin
                next_arg = w_args_q[k*DATA_W +: DATA_W];
            end
        end

        hdr_word                   = '0;
        hdr_word[DATA_W-1 -: 4]    = w_op_q;
        hdr_word[DATA_W-6 -: 3]    = w_argc_q;
        hdr_word[7:0]              = seq_q;

        // Push uses registered fullness only, so a same-cycle pop never frees a slot.
        if (bus.host_valid && !full) begin
            q_op_d[wr_ptr_q[AW-1:0]]   = bus.host_opcode;
            q_argc_d[wr_ptr_q[AW-1:0]] = (bus.host_argc > 3'd4) ? 3'd4 : bus.host_argc;
            q_args_d[wr_ptr_q[AW-1:0]] = bus.host_args;
            wr_ptr_d                   = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (bus.host_argc > 3'd4) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty && (outstanding_q < 4'(MAX_OUT))) begin
                    w_op_d   = q_op_q[rd_ptr_q[AW-1:0]];
                    w_argc_d = q_argc_q[rd_ptr_q[AW-1:0]];
                    w_args_d = q_args_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                // First HDR cycle loads the header; transfer handled once it is valid.
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = hdr_word;
                    cmd_last_d  = (w_argc_q == 3'd0);
                end else if (bus.cmd_ready) begin
                    hdr_xfer = 1'b1;
                    seq_d    = seq_q + 8'd1;
                    if (w_argc_q == 3'd0) begin
                        cmd_valid_d = 1'b0;
                        cmd_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d      = 2'd0;
                        cmd_data_d = w_args_q[DATA_W-1:0];
                        cmd_last_d = (w_argc_q == 3'd1);
                        state_d    = ST_ARG;
                    end
                end
            end
            ST_ARG: begin
                if (bus.cmd_ready) begin
                    if (cmd_last_q) begin
                        cmd_valid_d = 1'b0;
                        cmd_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d      = next_idx;
                        cmd_data_d = next_arg;
                        cmd_last_d = (({1'b0, next_idx} + 3'd1) == w_argc_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion alongside a header send nets to zero change.
        if (engine_done) begin
            if (outstanding_q != 4'd0 || hdr_xfer) begin
                credit_ret = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        outstanding_d = outstanding_q + {3'b000, hdr_xfer} - {3'b000, credit_ret};
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_op_q[i]   <= '0;
                q_argc_q[i] <= '0;
                q_args_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= ST_IDLE;
            w_op_q        <= '0;
            w_argc_q      <= '0;
            w_args_q      <= '0;
            idx_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_data_q    <= '0;
            cmd_last_q    <= 1'b0;
            seq_q         <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            q_op_q        <= q_op_d;
            q_argc_q      <= q_argc_d;
            q_args_q      <= q_args_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            w_op_q        <= w_op_d;
            w_argc_q      <= w_argc_d;
            w_args_q      <= w_args_d;
            idx_q         <= idx_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_data_q    <= cmd_data_d;
            cmd_last_q    <= cmd_last_d;
            seq_q         <= seq_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: tb/tb_cmd_packet_tx.sv
// Self-checking bench for cmd_packet_tx: directed vectors, multi-cycle
// corner sequences, and randomized traffic against a word-queue model.
module tb_cmd_packet_tx;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic       clk;
    logic       rst_;
    logic       engine_done;
    logic [3:0] outstanding;
    logic       busy;
    logic       err;

    cmd_packet_tx_if #(.DATA_W(DATA_W)) bus ();

    cmd_packet_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .bus         (bus),
        .engine_done (engine_done),
        .outstanding (outstanding),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        bit          last;
        bit          hdr;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] got[$];
    int unsigned m_out;
    bit          m_err;
    int unsigned m_seq;
    bit          seen_reset = 0;
    bit          stall_pending;
    logic [31:0] st_data;
    logic        st_last;

    // Queue every stream word a newly accepted command should produce.
    task automatic model_push(input logic [3:0] op, input logic [2:0] argc, input logic [127:0] args);
        int unsigned n;
        word_t w;
        n = (argc > 4) ? 4 : int'(argc);
        if (argc > 4) m_err = 1;
        w.data = (32'(op) << 28) | (32'(n) << 24) | 32'(m_seq);
        w.last = (n == 0);
        w.hdr  = 1;
        exp_q.push_back(w);
        m_seq = (m_seq + 1) % 256;
        for (int unsigned i = 0; i < n; i++) begin
            w.data = args[i*32 +: 32];
            w.last = (i == n - 1);
            w.hdr  = 0;
            exp_q.push_back(w);
        end
    endtask

    // Negedge monitor: compare DUT state against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        bit    hdr;
        word_t w;
        if (seen_reset) begin
            check("outstanding", 64'(outstanding), 64'(m_out));
            check("err", 64'(err), 64'(m_err));
            check("busy", 64'(busy), 64'((exp_q.size() != 0) || (m_out != 0)));
            check("credit_limit", 64'(outstanding <= 4'(MAX_OUT)), 64'(1));
            if (stall_pending) begin
                check("hold_valid", 64'(bus.cmd_valid), 64'(1));
                check("hold_data", 64'(bus.cmd_data), 64'(st_data));
                check("hold_last", 64'(bus.cmd_last), 64'(st_last));
            end
        end
        if (rst_) begin
            seen_reset    = 1;
            exp_q.delete();
            m_out         = 0;
            m_err         = 0;
            m_seq         = 0;
            stall_pending = 0;
        end else if (seen_reset) begin
            hdr = 0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                got.push_back(bus.cmd_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(bus.cmd_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", 64'(bus.cmd_data), 64'(w.data));
                    check("word_last", 64'(bus.cmd_last), 64'(w.last));
                    hdr = w.hdr;
                end
            end
            stall_pending = bus.cmd_valid && !bus.cmd_ready;
            st_data       = bus.cmd_data;
            st_last       = bus.cmd_last;
            if (engine_done && !hdr) begin
                if (m_out == 0) m_err = 1;
                else m_out--;
            end else if (hdr && !engine_done) begin
                m_out++;
            end
            if (bus.host_valid && bus.host_ready)
                model_push(bus.host_opcode, bus.host_argc, bus.host_args);
        end
    end

    // ---------------- cmd_ready driver ----------------
    int unsigned ready_mode;   // 0: constant, 1: repeating 5-bit pattern, 2: random
    logic        ready_const;
    logic [4:0]  ready_pat;
    int unsigned pat_i;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: bus.cmd_ready = ready_const;
            1: begin
                bus.cmd_ready = ready_pat[pat_i % 5];
                pat_i++;
            end
            default: bus.cmd_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int unsigned mode, input logic c, input logic [4:0] pat);
        ready_mode  = mode;
        ready_const = c;
        ready_pat   = pat;
        pat_i       = 0;
    endtask

    task automatic do_reset();
        rst_           = 1;
        bus.host_valid = 0;
        engine_done    = 0;
        tick();
        tick();
        rst_ = 0;
        check("rst_host_ready", 64'(bus.host_ready), 64'(1));
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
        check("rst_cmd_last", 64'(bus.cmd_last), 64'(0));
        check("rst_cmd_data", 64'(bus.cmd_data), 64'(0));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic push(input logic [3:0] op, input logic [2:0] argc, input logic [127:0] args);
        bit done;
        done            = 0;
        bus.host_valid  = 1;
        bus.host_opcode = op;
        bus.host_argc   = argc;
        bus.host_args   = args;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.host_ready) done = 1;
            tick();
        end
        bus.host_valid = 0;
        if (!done) check("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_words(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget && got.size() < n; i++) tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]   op;
        logic [2:0]   argc;
        logic [127:0] args;
        logic [4:0]   pat;
        logic [31:0]  exp_hdr;
        int unsigned  exp_words;
        bit           exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int unsigned c;
        logic [2:0]  a;
        bit          last_rdy;
        bit          acc;

        vecs[0] = '{4'h3, 3'd2, {64'h0, 32'h2222_2222, 32'h1111_1111}, 5'b11111, 32'h3200_0000, 3, 0};
        vecs[1] = '{4'h3, 3'd2, {64'h0, 32'h2222_2222, 32'h1111_1111}, 5'b10010, 32'h3200_0000, 3, 0};
        vecs[2] = '{4'hA, 3'd4, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 5'b10110, 32'hA400_0000, 5, 0};
        vecs[3] = '{4'h5, 3'd6, {32'h4, 32'h3, 32'h2, 32'h1}, 5'b11111, 32'h5400_0000, 5, 1};
        vecs[4] = '{4'hF, 3'd0, 128'h0, 5'b01011, 32'hF000_0000, 1, 0};
        vecs[5] = '{4'h1, 3'd1, {96'h0, 32'hDEAD_BEEF}, 5'b11001, 32'h1100_0000, 2, 0};

        bus.host_valid  = 0;
        bus.host_opcode = 0;
        bus.host_argc   = 0;
        bus.host_args   = 0;
        engine_done     = 0;
        set_ready(0, 1'b0, 5'b0);

        foreach (vecs[v]) begin
            do_reset();
            set_ready(1, 1'b0, vecs[v].pat);
            got.delete();
            push(vecs[v].op, vecs[v].argc, vecs[v].args);
            c = 0;
            while (!bus.cmd_valid && c < 10) begin
                tick();
                c++;
            end
            check("hdr_latency", 64'(c), 64'(2));
            wait_words(vecs[v].exp_words, 200);
            repeat (6) tick();
            check("vec_words", 64'(got.size()), 64'(vecs[v].exp_words));
            if (got.size() > 0) check("vec_hdr", 64'(got[0]), 64'(vecs[v].exp_hdr));
            check("vec_err", 64'(err), 64'(vecs[v].exp_err));
            check("vec_outstanding", 64'(outstanding), 64'(1));
        end

        // Credit limit: third packet waits until a completion returns a credit.
        do_reset();
        set_ready(0, 1'b1, 5'b0);
        got.delete();
        push(4'h1, 3'd0, 128'h0);
        push(4'h2, 3'd0, 128'h0);
        push(4'h3, 3'd0, 128'h0);
        repeat (20) tick();
        check("credit_sent", 64'(got.size()), 64'(2));
        if (got.size() > 1) check("credit_seq1", 64'(got[1]), 64'h2000_0001);
        check("credit_out", 64'(outstanding), 64'(2));
        check("credit_busy", 64'(busy), 64'(1));
        engine_done = 1;
        tick();
        engine_done = 0;
        repeat (15) tick();
        check("credit_third", 64'(got.size()), 64'(3));
        if (got.size() > 2) check("credit_seq2", 64'(got[2]), 64'h3000_0002);
        check("credit_out_after", 64'(outstanding), 64'(2));

        // Queue full: no credit, so nothing pops; four accepts fill the queue.
        set_ready(0, 1'b0, 5'b0);
        for (int i = 0; i < 4; i++) push(4'(i + 4), 3'd1, 128'(i));
        check("full_host_ready", 64'(bus.host_ready), 64'(0));
        bus.host_valid  = 1;
        bus.host_opcode = 4'h9;
        bus.host_argc   = 3'd0;
        repeat (5) tick();
        check("full_held", 64'(bus.host_ready), 64'(0));
        bus.host_valid = 0;

        // Spurious completion with no packets in flight.
        do_reset();
        engine_done = 1;
        tick();
        engine_done = 0;
        tick();
        check("spurious_done_err", 64'(err), 64'(1));
        check("spurious_done_out", 64'(outstanding), 64'(0));

        // Reset in the middle of argument words truncates the packet.
        do_reset();
        set_ready(0, 1'b1, 5'b0);
        got.delete();
        push(4'h6, 3'd4, {32'h4, 32'h3, 32'h2, 32'h1});
        wait_words(2, 50);
        set_ready(0, 1'b0, 5'b0);
        tick();
        check("midpkt_valid", 64'(bus.cmd_valid), 64'(1));
        rst_ = 1;
        tick();
        rst_ = 0;
        check("midrst_valid", 64'(bus.cmd_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_host_ready", 64'(bus.host_ready), 64'(1));
        set_ready(0, 1'b1, 5'b0);
        got.delete();
        push(4'h9, 3'd0, 128'h0);
        wait_words(1, 20);
        repeat (4) tick();
        check("midrst_words", 64'(got.size()), 64'(1));
        if (got.size() > 0) check("midrst_seq0", 64'(got[0]), 64'h9000_0000);

        // Randomized traffic against the model.
        do_reset();
        set_ready(2, 1'b0, 5'b0);
        last_rdy = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            acc = bus.host_valid && last_rdy;
            if (!bus.host_valid || acc) begin
                bus.host_valid = ($urandom_range(0, 2) == 0);
                a = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                bus.host_opcode = 4'($urandom);
                bus.host_argc   = a;
                bus.host_args   = {$urandom, $urandom, $urandom, $urandom};
            end
            last_rdy    = bus.host_ready;
            engine_done = ($urandom_range(0, 5) == 0);
            tick();
        end
        bus.host_valid = 0;
        set_ready(0, 1'b1, 5'b0);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            engine_done = ($urandom_range(0, 3) == 0);
            tick();
        end
        engine_done = 0;
        tick();
        check("rand_drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_packet_tx.md
Name: cmd_packet_tx

Overview:
- Transmit end of the command-processor input link.
- Accepts whole commands from the host side (opcode, argument count, up to 4 argument words) into a small queue.
- Serializes each command as a header word followed by its argument words, using a valid/ready stream into the command processor.
- Limits in-flight packets with a credit counter that is returned by engine completion pulses.

Parameters:
- DATA_W, 32, width of each stream word and each argument word (≥ 16).
- DEPTH, 4, host command queue entries (power of 2, ≥ 2).
- MAX_OUT, 2, maximum packets sent but not yet completed by engines (1–15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  synchronous reset, active-high: asserted high, sampled on rising clk.
- host_valid  in  1  host command present.
- host_ready  out  1  queue can accept a command.
- host_opcode  in  4  command opcode.
- host_argc  in  3  argument count, legal range 0–4.
- host_args  in  4*DATA_W  argument words; arg0 in bits [DATA_W-1:0].
- cmd_valid  out  1  stream word valid.
- cmd_ready  in  1  command processor accepts the word.
- cmd_data  out  DATA_W  stream word.
- cmd_last  out  1  final word of the packet.
- engine_done  in  1  one-cycle pulse; one packet completed.
- outstanding  out  4  packets in flight.
- busy  out  1  block not quiescent.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset: on rst_=1 at a rising edge, the following clear at that edge:
  - Queue empty; host_ready=1.
  - cmd_valid=0, cmd_last=0, cmd_data=0.
  - outstanding=0, seq=0, err=0, busy=0, state=IDLE.
  - Reset mid-packet truncates the packet; no remaining words are sent.
- Host push:
  - Accepted when host_valid && host_ready.
  - host_ready = !full, computed from registered queue state. A push is blocked when the queue is full, even if a pop occurs in the same cycle.
  - host_argc > 4 is stored as 4 and sets err.
- FSM states: IDLE, HDR, ARG.
- IDLE:
  - If the queue is non-empty and outstanding < MAX_OUT: pop the head entry into working registers, go to HDR.
  - Otherwise stay in IDLE.
- HDR:
  - cmd_valid=1.
  - cmd_data = {opcode in [DATA_W-1:DATA_W-4], 1'b0, argc in [DATA_W-6:DATA_W-8], zeros, seq in [7:0]}.
  - cmd_last = (argc == 0).
  - On transfer (cmd_valid && cmd_ready): seq increments, wrapping 255→0; outstanding increments. If argc == 0 go to IDLE, else go to ARG with idx=0.
- ARG:
  - cmd_valid=1, cmd_data = arg[idx], cmd_last = (idx == argc-1).
  - On transfer: if last go to IDLE, else idx+1.
- Stream rules:
  - cmd_data and cmd_last are registered.
  - Both hold stable while cmd_valid && !cmd_ready.
  - cmd_valid never drops before its transfer.
- Latency:
  - Host push at edge N into an empty queue with the block idle and credit available: cmd_valid=1 with the header after edge N+2.
  - At least one IDLE cycle separates consecutive packets.
- Credits:
  - engine_done decrements outstanding.
  - Header transfer and engine_done in the same cycle: outstanding unchanged.
  - engine_done while outstanding=0 (and no concurrent increment): ignored, sets err.
  - outstanding never exceeds MAX_OUT.
- busy = (state != IDLE) || queue non-empty || outstanding != 0.
- err clears only on reset.

Test Plan:
- Reset then idle → host_ready=1, cmd_valid=0, outstanding=0, busy=0, err=0.
- Push opcode=4'h3, argc=2, args {0x11111111, 0x22222222}, cmd_ready=1 held → exactly 3 words:
  - 0x32000000 (seq 0).
  - 0x11111111.
  - 0x22222222 with cmd_last=1.
  - outstanding=1; header visible 2 cycles after push.
- Same packet with cmd_ready toggling 0,1,0,0,1 → each word held stable until accepted; no word lost or duplicated.
- MAX_OUT=2: push 3 argc=0 commands with no engine_done → two headers sent (seq 0,1), third waits in queue. Pulse engine_done → third header (seq 2) sent; outstanding stays 2.
- Push DEPTH+1 commands with cmd_ready=0 → host_ready falls after the 4th accept; the 5th is held; engine_done at outstanding=0 sets err=1.
- Assert rst_ for one cycle during an ARG word → next cycle cmd_valid=0, queue empty, seq=0. A subsequent packet header carries seq 0.
